// File: rtl/cc_random_row_scheduler.sv
// Road-row scheduler: issues one NADA/RANDOM row decision per game tick over a
// valid/ack handshake, with a one-deep tick buffer and a sticky overrun flag.
module cc_random_row_scheduler #(
  parameter int         RANDOMSCHED_PERIOD      = 4,
  parameter int         RANDOMSCHED_PERIODWIDTH = 8,
  parameter logic [7:0] RANDOMSCHED_SEED        = 8'h01
) (
  input  logic       CC_RANDOMSCHED_CLOCK_50,
  input  logic       CC_RANDOMSCHED_RESET_InHigh,
  input  logic       CC_RANDOMSCHED_enable_In,
  input  logic       CC_RANDOMSCHED_tick_In,
  input  logic       CC_RANDOMSCHED_ack_In,
  output logic       CC_RANDOMSCHED_select_Out,
  output logic [7:0] CC_RANDOMSCHED_RANDOM_OutBUS,
  output logic       CC_RANDOMSCHED_valid_Out,
  output logic       CC_RANDOMSCHED_overrun_Out
);

  localparam int W = RANDOMSCHED_PERIODWIDTH;
  localparam logic [W-1:0] LAST_ROW = W'(RANDOMSCHED_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, ARMED, ISSUE} state_t;

  state_t       state_reg, state_next;
  logic [7:0]   lfsr_reg, lfsr_next;
  logic [W-1:0] count_reg, count_next;
  logic         pending_reg, pending_next;
  logic         overrun_reg, overrun_next;
  logic         valid_reg, valid_next;
  logic         select_reg, select_next;
  logic [7:0]   data_reg, data_next;
  logic         decide;

  // Taps 8,6,5,4 give a maximal-length sequence; an all-zero state would lock up.
  always_comb begin
    if (lfsr_reg == 8'h00) begin
      lfsr_next = RANDOMSCHED_SEED;
    end else begin
      lfsr_next = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    end
  end

  always_ff @(posedge CC_RANDOMSCHED_CLOCK_50) begin
    if (CC_RANDOMSCHED_RESET_InHigh) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  assign decide = CC_RANDOMSCHED_tick_In || pending_reg;

  always_comb begin
    state_next = state_reg;
    if (!CC_RANDOMSCHED_enable_In) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    state_next = ARMED;
        ARMED:   if (decide) state_next = ISSUE;
        ISSUE:   if (CC_RANDOMSCHED_ack_In) state_next = ARMED;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    count_next   = count_reg;
    pending_next = pending_reg;
    overrun_next = overrun_reg;
    valid_next   = valid_reg;
    select_next  = select_reg;
    data_next    = data_reg;
    if (!CC_RANDOMSCHED_enable_In) begin
      count_next   = '0;
      pending_next = 1'b0;
      overrun_next = 1'b0;
      valid_next   = 1'b0;
      select_next  = 1'b0;
      data_next    = 8'h00;
    end else begin
      case (state_reg)
        ARMED: begin
          if (decide) begin
            // A tick arriving while a buffered one is served stays buffered.
            pending_next = pending_reg && CC_RANDOMSCHED_tick_In;
            valid_next   = 1'b1;
            if (count_reg == LAST_ROW) begin
              select_next = 1'b1;
              data_next   = (lfsr_reg == 8'hFF) ? 8'hFE : lfsr_reg;
              count_next  = '0;
            end else begin
              select_next = 1'b0;
              data_next   = 8'h00;
              count_next  = count_reg + W'(1);
            end
          end
        end
        ISSUE: begin
          if (CC_RANDOMSCHED_tick_In) begin
            if (pending_reg) overrun_next = 1'b1;
            else             pending_next = 1'b1;
          end
          if (CC_RANDOMSCHED_ack_In) valid_next = 1'b0;
        end
        default: valid_next = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CC_RANDOMSCHED_CLOCK_50) begin
    if (CC_RANDOMSCHED_RESET_InHigh) begin
      lfsr_reg    <= RANDOMSCHED_SEED;
      count_reg   <= '0;
      pending_reg <= 1'b0;
      overrun_reg <= 1'b0;
      valid_reg   <= 1'b0;
      select_reg  <= 1'b0;
      data_reg    <= 8'h00;
    end else begin
      lfsr_reg    <= lfsr_next;
      count_reg   <= count_next;
      pending_reg <= pending_next;
      overrun_reg <= overrun_next;
      valid_reg   <= valid_next;
      select_reg  <= select_next;
      data_reg    <= data_next;
    end
  end

  assign CC_RANDOMSCHED_select_Out    = select_reg;
  assign CC_RANDOMSCHED_RANDOM_OutBUS = data_reg;
  assign CC_RANDOMSCHED_valid_Out     = valid_reg;
  assign CC_RANDOMSCHED_overrun_Out   = overrun_reg;

endmodule

// File: tb/tb_cc_random_row_scheduler.sv
// Directed bench for cc_random_row_scheduler: row cadence, tick buffering,
// overrun, full-row guard, enable drop and mid-transfer reset.
module tb_cc_random_row_scheduler;

  logic       clk = 1'b0;
  logic       srst, enable, tick, ack;
  logic       select, valid, overrun;
  logic [7:0] data;
  logic [7:0] tb_lfsr;
  int         total = 0;
  int         bad = 0;
  bit         found;

  cc_random_row_scheduler #(
    .RANDOMSCHED_PERIOD(4),
    .RANDOMSCHED_PERIODWIDTH(8),
    .RANDOMSCHED_SEED(8'h01)
  ) dut (
    .CC_RANDOMSCHED_CLOCK_50(clk),
    .CC_RANDOMSCHED_RESET_InHigh(srst),
    .CC_RANDOMSCHED_enable_In(enable),
    .CC_RANDOMSCHED_tick_In(tick),
    .CC_RANDOMSCHED_ack_In(ack),
    .CC_RANDOMSCHED_select_Out(select),
    .CC_RANDOMSCHED_RANDOM_OutBUS(data),
    .CC_RANDOMSCHED_valid_Out(valid),
    .CC_RANDOMSCHED_overrun_Out(overrun)
  );

  always #5 clk = ~clk;

  // Reference LFSR from the polynomial x^8+x^6+x^5+x^4+1, seed 01.
  always @(posedge clk) begin
    if (srst)                 tb_lfsr <= 8'h01;
    else if (tb_lfsr == 8'h0) tb_lfsr <= 8'h01;
    else tb_lfsr <= {tb_lfsr[6:0], tb_lfsr[7] ^ tb_lfsr[5] ^ tb_lfsr[4] ^ tb_lfsr[3]};
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] guard(input logic [7:0] x);
    return (x == 8'hFF) ? 8'hFE : x;
  endfunction

  task automatic do_row(input string tag, input bit is_rand, input bit use_fixed,
                        input logic [7:0] fixed);
    logic [7:0] cap;
    logic [7:0] exp;
    cap  = tb_lfsr;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    exp = is_rand ? (use_fixed ? fixed : guard(cap)) : 8'h00;
    chk({tag, "_valid"}, {7'b0, valid}, 8'h01);
    chk({tag, "_select"}, {7'b0, select}, {7'b0, is_rand});
    chk({tag, "_data"}, data, exp);
    $display("row %s: select=%0d data=%h", tag, select, data);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    chk({tag, "_ackdrop"}, {7'b0, valid}, 8'h00);
  endtask

  initial begin
    logic [7:0] cap;
    srst = 1'b1; enable = 1'b0; tick = 1'b0; ack = 1'b0;
    repeat (3) cyc();
    srst = 1'b0;
    chk("rst_valid", {7'b0, valid}, 8'h00);
    chk("rst_select", {7'b0, select}, 8'h00);
    chk("rst_data", data, 8'h00);
    chk("rst_overrun", {7'b0, overrun}, 8'h00);

    // Basic cadence: three NADA rows, one RANDOM, then NADA again.
    enable = 1'b1;
    cyc();
    for (int r = 0; r < 5; r++) begin
      repeat (8) cyc();
      do_row($sformatf("t1_r%0d", r), (r == 3), 1'b0, 8'h00);
    end

    // Ticks during ISSUE: first buffered, second dropped with overrun.
    tick = 1'b1; cyc();
    chk("t2_valid", {7'b0, valid}, 8'h01);
    chk("t2_select", {7'b0, select}, 8'h00);
    cyc();
    chk("t2_pend_ovr", {7'b0, overrun}, 8'h00);
    cyc();
    chk("t2_overrun", {7'b0, overrun}, 8'h01);
    tick = 1'b0; ack = 1'b1; cyc(); ack = 1'b0;
    chk("t2_gap", {7'b0, valid}, 8'h00);
    cyc();
    chk("t2_pend_valid", {7'b0, valid}, 8'h01);
    chk("t2_pend_select", {7'b0, select}, 8'h00);
    chk("t2_sticky", {7'b0, overrun}, 8'h01);
    $display("row t2_pend: select=%0d data=%h overrun=%0d", select, data, overrun);
    ack = 1'b1; cyc(); ack = 1'b0;
    chk("t2_ackdrop", {7'b0, valid}, 8'h00);

    // Enable drop while a RANDOM row is pending, then counter restart.
    cap = tb_lfsr; tick = 1'b1; cyc(); tick = 1'b0;
    chk("t5_valid", {7'b0, valid}, 8'h01);
    chk("t5_select", {7'b0, select}, 8'h01);
    chk("t5_data", data, guard(cap));
    enable = 1'b0; cyc();
    chk("t5_off_valid", {7'b0, valid}, 8'h00);
    chk("t5_off_select", {7'b0, select}, 8'h00);
    chk("t5_off_data", data, 8'h00);
    chk("t5_off_overrun", {7'b0, overrun}, 8'h00);
    enable = 1'b1; cyc();
    for (int r = 0; r < 4; r++) do_row($sformatf("t5_r%0d", r), (r == 3), 1'b0, 8'h00);

    // Tick and ack together: one-cycle gap, next decision, no overrun.
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("t3_valid", {7'b0, valid}, 8'h01);
    tick = 1'b1; ack = 1'b1; cyc(); tick = 1'b0; ack = 1'b0;
    chk("t3_gap", {7'b0, valid}, 8'h00);
    cyc();
    chk("t3_next_valid", {7'b0, valid}, 8'h01);
    chk("t3_next_select", {7'b0, select}, 8'h00);
    chk("t3_overrun", {7'b0, overrun}, 8'h00);
    $display("row t3_next: select=%0d data=%h", select, data);
    ack = 1'b1; cyc(); ack = 1'b0;
    chk("t3_ackdrop", {7'b0, valid}, 8'h00);

    // Full-row guard: line the RANDOM row up with LFSR == FF.
    do_row("t4_pre", 1'b0, 1'b0, 8'h00);
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (tb_lfsr == 8'hFF) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    chk("t4_found_ff", {7'b0, found}, 8'h01);
    do_row("t4_ff", 1'b1, 1'b1, 8'hFE);

    // Reset mid-ISSUE with pending and overrun set.
    tick = 1'b1; cyc(); cyc(); cyc(); tick = 1'b0;
    chk("t6_pre_overrun", {7'b0, overrun}, 8'h01);
    chk("t6_pre_valid", {7'b0, valid}, 8'h01);
    srst = 1'b1; cyc(); srst = 1'b0;
    chk("t6_rst_valid", {7'b0, valid}, 8'h00);
    chk("t6_rst_select", {7'b0, select}, 8'h00);
    chk("t6_rst_data", data, 8'h00);
    chk("t6_rst_overrun", {7'b0, overrun}, 8'h00);
    cyc();
    // Ticks land on edges 2,4,6,8 after reset; the 4th samples seq[7] = 8E.
    for (int r = 0; r < 4; r++) do_row($sformatf("t6_r%0d", r), (r == 3), (r == 3), 8'h8E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
